debounce_edge: RTL and testbench

- Conditions a raw asynchronous input (push-button or external strobe) into a clean, clock-domain-safe level plus single-cycle edge pulses.
- Sits directly upstream of the team's D flip-flop and register stages; `dout`, `rise` and `fall` drive their `d` and enable inputs.
- Contains a synchronizer chain, a consecutive-sample counter and a 4-state FSM.

---
 rtl/debounce_edge_pkg.sv | 25 ++
 rtl/debounce_edge_sync.sv | 25 ++
 rtl/debounce_edge.sv | 107 ++++++++++
 tb/tb_debounce_edge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_edge_pkg.sv
// Shared types and limits for the debounce_edge input-conditioning slice.
// Gray-style state codes so that busy is simply the XOR of the two state bits.
package debounce_edge_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b11,
        CHK_LO    = 2'b10
    } db_state_t;

    localparam int SYNC_MIN   = 2;
    localparam int SYNC_MAX   = 4;
    localparam int STABLE_MIN = 2;
    localparam int STABLE_MAX = 65535;

    function automatic logic state_busy(input db_state_t st);
        return st[0] ^ st[1];
    endfunction

    function automatic db_state_t rest_state(input logic level);
        return level ? STABLE_HI : STABLE_LO;
    endfunction

endpackage

// File: rtl/debounce_edge_sync.sv
// Multi-flop synchronizer for a raw asynchronous level.
// Reused by other input-conditioning blocks; s is the last stage.
module sync_chain #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s
);

    logic [SYNC_STAGES-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            q <= {q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw input into a clean level plus single-cycle rise/fall pulses.
// A change is accepted only after STABLE_CYCLES consecutive synchronized samples.
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("debounce_edge: SYNC_STAGES out of range");
    end

    if (STABLE_CYCLES < STABLE_MIN || STABLE_CYCLES > STABLE_MAX) begin : g_bad_stable
        $error("debounce_edge: STABLE_CYCLES out of range");
    end

    logic       s;
    logic [CW-1:0] cnt;
    db_state_t  state;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (din),
        .s   (s)
    );

    // cnt counts opposite samples seen so far; the switch fires on the
    // STABLE_CYCLES-th one, so cnt never climbs past STABLE_CYCLES-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= rest_state(RESET_LEVEL);
            dout  <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                STABLE_LO: begin
                    if (s) begin
                        state <= CHK_HI;
                        cnt   <= ONE;
                        busy  <= state_busy(CHK_HI);
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        busy  <= state_busy(STABLE_LO);
                    end else if (cnt == LAST) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        dout  <= 1'b1;
                        rise  <= 1'b1;
                        busy  <= state_busy(STABLE_HI);
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state <= CHK_LO;
                        cnt   <= ONE;
                        busy  <= state_busy(CHK_LO);
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        busy  <= state_busy(STABLE_HI);
                    end else if (cnt == LAST) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        dout  <= 1'b0;
                        fall  <= 1'b1;
                        busy  <= state_busy(STABLE_LO);
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: default instance plus a 3/10/reset-high instance.
// Reference tracks the run length of synchronized samples that disagree with dout.
module tb_debounce_edge;

    logic clk = 1'b0;
    logic rst0, rst1;
    logic din0, din1;
    logic dout0, rise0, fall0, busy0;
    logic dout1, rise1, fall1, busy1;

    int checks = 0;
    int errors = 0;

    int S [2] = '{2, 3};
    int N [2] = '{4, 10};
    bit RL[2] = '{1'b0, 1'b1};

    bit pipe[2][4];
    int run [2];
    bit rd  [2];
    bit er  [2];
    bit ef  [2];

    always #5 clk = ~clk;

    debounce_edge dut0 (
        .clk  (clk),
        .rst  (rst0),
        .din  (din0),
        .dout (dout0),
        .rise (rise0),
        .fall (fall0),
        .busy (busy0)
    );

    debounce_edge #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (10),
        .RESET_LEVEL   (1'b1)
    ) dut1 (
        .clk  (clk),
        .rst  (rst1),
        .din  (din1),
        .dout (dout1),
        .rise (rise1),
        .fall (fall1),
        .busy (busy1)
    );

    function automatic void m_reset(input int id);
        for (int i = 0; i < 4; i++) pipe[id][i] = RL[id];
        run[id] = 0;
        rd[id]  = RL[id];
        er[id]  = 1'b0;
        ef[id]  = 1'b0;
    endfunction

    // Sample seen by the debouncer at an edge is din from S edges earlier.
    function automatic void m_step(input int id, input bit d);
        bit v;
        v = pipe[id][S[id]-1];
        for (int i = 3; i > 0; i--) pipe[id][i] = pipe[id][i-1];
        pipe[id][0] = d;
        er[id] = 1'b0;
        ef[id] = 1'b0;
        if (v != rd[id]) begin
            run[id]++;
            if (run[id] == N[id]) begin
                rd[id]  = v;
                er[id]  = v;
                ef[id]  = !v;
                run[id] = 0;
            end
        end else begin
            run[id] = 0;
        end
    endfunction

    always @(posedge clk or posedge rst0)
        if (rst0) m_reset(0); else m_step(0, din0);

    always @(posedge clk or posedge rst1)
        if (rst1) m_reset(1); else m_step(1, din1);

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("dout0", dout0, rd[0]);
        chk("rise0", rise0, er[0]);
        chk("fall0", fall0, ef[0]);
        chk("busy0", busy0, run[0] != 0);
        chk("excl0", rise0 & fall0, 1'b0);
        chk("dout1", dout1, rd[1]);
        chk("rise1", rise1, er[1]);
        chk("fall1", fall1, ef[1]);
        chk("busy1", busy1, run[1] != 0);
        chk("excl1", rise1 & fall1, 1'b0);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            cmp_all();
        end
    endtask

    task automatic measure(input int id, input int maxc,
                           output int at, output int cnt);
        logic p;
        at  = -1;
        cnt = 0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            cmp_all();
            p = (id == 0) ? (rise0 | fall0) : (rise1 | fall1);
            if (p) begin
                cnt++;
                if (at < 0) at = k;
            end
        end
    endtask

    initial begin
        int at, cnt, h0, h1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        din0 = 1'b0;
        din1 = 1'b1;
        m_reset(0);
        m_reset(1);
        repeat (2) @(negedge clk);
        chk("rst_dout0", dout0, 1'b0);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_rise0", rise0, 1'b0);
        chk("rst_fall0", fall0, 1'b0);
        chk("rst_dout1", dout1, 1'b1);
        chk("rst_busy1", busy1, 1'b0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        measure(0, 20, at, cnt);
        chki("idle_pulses0", cnt, 0);
        measure(1, 20, at, cnt);
        chki("idle_pulses1", cnt, 0);

        din0 = 1'b1; cyc(2);
        din0 = 1'b0; cyc(1);
        din0 = 1'b1; cyc(3);
        din0 = 1'b0;
        measure(0, 15, at, cnt);
        chki("bounce_pulses", cnt, 0);
        chk("bounce_dout", dout0, 1'b0);

        din0 = 1'b1;
        measure(0, 12, at, cnt);
        chki("rise_latency", at, 6);
        chki("rise_count", cnt, 1);
        chk("rise_dout", dout0, 1'b1);

        din0 = 1'b0;
        measure(0, 12, at, cnt);
        chki("fall_latency", at, 6);
        chki("fall_count", cnt, 1);
        chk("fall_dout", dout0, 1'b0);

        din0 = 1'b1;
        cyc(3);
        chk("midq_busy", busy0, 1'b1);
        #1 rst0 = 1'b1;
        #1;
        chk("midq_dout", dout0, 1'b0);
        chk("midq_busy_clr", busy0, 1'b0);
        chk("midq_rise", rise0, 1'b0);
        chk("midq_fall", fall0, 1'b0);
        cyc(2);
        rst0 = 1'b0;
        measure(0, 12, at, cnt);
        chki("midq_latency", at, 6);
        chki("midq_count", cnt, 1);
        din0 = 1'b0;
        cyc(8);

        din1 = 1'b0;
        measure(1, 20, at, cnt);
        chki("sweep_latency", at, 13);
        chki("sweep_count", cnt, 1);
        chk("sweep_dout", dout1, 1'b0);

        h0 = 0;
        h1 = 0;
        repeat (600) begin
            if (h0 == 0) begin
                din0 = 1'($urandom % 2);
                h0   = int'($urandom_range(1, 7));
            end
            if (h1 == 0) begin
                din1 = 1'($urandom % 2);
                h1   = int'($urandom_range(1, 14));
            end
            h0--;
            h1--;
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
